// File: rtl/split_bus_delayer_pro.sv
// Delay/buffer stage for one split-transaction memory channel: bypass, fixed
// or LFSR-random latency on the request and response phases.
//
//   state   | meaning
//   R_IDLE  | waiting for an admissible host request
//   R_WAIT  | request delay counting down
//   R_FWD   | target_req held until target_ack
//   S_IDLE  | response stage waiting for FIFO data
//   S_COUNT | response delay counting down, host_resp when it reaches 0
module split_bus_delayer_pro #(
    parameter int          ADDR_W          = 32,
    parameter int          DATA_W          = 32,
    parameter int          REQ_DELAY_MAX   = 8,
    parameter int          RESP_DELAY_MAX  = 6,
    parameter int          RESP_FIFO_POW   = 4,
    parameter int          MAX_OUTSTANDING = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [1:0]                             mode_i,
    input  logic [$clog2(REQ_DELAY_MAX+1)-1:0]     fixed_req_delay_i,
    input  logic [$clog2(RESP_DELAY_MAX+1)-1:0]    fixed_resp_delay_i,
    input  logic                                   host_req,
    input  logic                                   host_we,
    input  logic [ADDR_W-1:0]                      host_addr,
    input  logic [DATA_W-1:0]                      host_wdata,
    input  logic [DATA_W/8-1:0]                    host_be,
    output logic                                   host_ack,
    output logic                                   host_resp,
    output logic [DATA_W-1:0]                      host_rdata,
    output logic                                   target_req,
    output logic                                   target_we,
    output logic [ADDR_W-1:0]                      target_addr,
    output logic [DATA_W-1:0]                      target_wdata,
    output logic [DATA_W/8-1:0]                    target_be,
    input  logic                                   target_ack,
    input  logic                                   target_resp,
    input  logic [DATA_W-1:0]                      target_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   overflow_o
);
    localparam int REQ_CW = $clog2(REQ_DELAY_MAX+1);
    localparam int RSP_CW = $clog2(RESP_DELAY_MAX+1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING+1);
    localparam int DEPTH  = 1 << RESP_FIFO_POW;
    localparam logic [REQ_CW-1:0] REQ_MAX_C = REQ_CW'(REQ_DELAY_MAX);
    localparam logic [RSP_CW-1:0] RSP_MAX_C = RSP_CW'(RESP_DELAY_MAX);
    localparam logic [OUT_W-1:0]  OUT_MAX_C = OUT_W'(MAX_OUTSTANDING);
    localparam logic [RESP_FIFO_POW:0] FULL_XOR = {1'b1, {RESP_FIFO_POW{1'b0}}};

    if (MAX_OUTSTANDING > DEPTH) begin : g_bad_outstanding
        $error("MAX_OUTSTANDING exceeds response FIFO depth");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FWD} req_state_t;
    typedef enum logic {S_IDLE, S_COUNT} rsp_state_t;

    req_state_t            req_state;
    rsp_state_t            rsp_state;
    logic [1:0]            mode_q;
    logic [15:0]           lfsr_q;
    logic [REQ_CW-1:0]     req_cnt;
    logic [RSP_CW-1:0]     resp_cnt;
    logic [OUT_W-1:0]      outstanding_q;
    logic                  overflow_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [RESP_FIFO_POW:0] wr_ptr, rd_ptr;

    logic bypass, room, req_ok, fifo_empty, fifo_full, push, pop, quiet, accept_rd;
    logic [7:0]        rnd_req, rnd_rsp;
    logic [REQ_CW-1:0] d_req;
    logic [RSP_CW-1:0] d_resp;

    assign bypass     = (mode_q == 2'd0);
    assign room       = (outstanding_q < OUT_MAX_C);
    assign req_ok     = host_req & (host_we | room);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign push       = ~bypass & target_resp & ~fifo_full;
    assign pop        = ~bypass & (rsp_state == S_IDLE) & ~fifo_empty;

    assign rnd_req = lfsr_q[7:0]  % 8'(REQ_DELAY_MAX + 1);
    assign rnd_rsp = lfsr_q[15:8] % 8'(RESP_DELAY_MAX + 1);
    assign d_req  = (mode_q == 2'd1) ? ((fixed_req_delay_i > REQ_MAX_C) ? REQ_MAX_C : fixed_req_delay_i)
                                     : REQ_CW'(rnd_req);
    assign d_resp = (mode_q == 2'd1) ? ((fixed_resp_delay_i > RSP_MAX_C) ? RSP_MAX_C : fixed_resp_delay_i)
                                     : RSP_CW'(rnd_rsp);

    // Outputs are gated while reset is held so bypass cannot leak a strobe.
    assign target_req   = ~rst_i & (bypass ? req_ok : (req_state == R_FWD));
    assign host_ack     = target_req & target_ack;
    assign target_we    = host_we;
    assign target_addr  = host_addr;
    assign target_wdata = host_wdata;
    assign target_be    = host_be;
    assign host_resp    = ~rst_i & (bypass ? target_resp : (rsp_state == S_COUNT && resp_cnt == '0));
    assign host_rdata   = bypass ? target_rdata : rdata_q;
    assign accept_rd    = target_req & target_ack & ~host_we;
    assign outstanding_o = outstanding_q;
    assign overflow_o    = overflow_q;

    // A request starting this cycle counts as activity, so the mode never
    // changes underneath a freshly loaded delay.
    assign quiet = (req_state == R_IDLE) && (rsp_state == S_IDLE) && (outstanding_q == '0)
                   && fifo_empty && !(!bypass && req_ok);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[RESP_FIFO_POW-1:0]] <= target_rdata;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_state     <= R_IDLE;
            rsp_state     <= S_IDLE;
            mode_q        <= 2'd0;
            lfsr_q        <= LFSR_SEED;
            req_cnt       <= '0;
            resp_cnt      <= '0;
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
            rdata_q       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
            if (quiet) mode_q <= mode_i;

            case (req_state)
                R_IDLE: if (!bypass && req_ok) begin
                    req_cnt   <= d_req;
                    req_state <= R_WAIT;
                end
                R_WAIT: if (req_cnt == '0) req_state <= R_FWD;
                        else req_cnt <= req_cnt - 1'b1;
                R_FWD:  if (target_ack) req_state <= R_IDLE;
                default: req_state <= R_IDLE;
            endcase

            case (rsp_state)
                S_IDLE: if (pop) begin
                    rdata_q   <= mem[rd_ptr[RESP_FIFO_POW-1:0]];
                    resp_cnt  <= d_resp;
                    rsp_state <= S_COUNT;
                end
                S_COUNT: if (resp_cnt == '0) rsp_state <= S_IDLE;
                         else resp_cnt <= resp_cnt - 1'b1;
                default: rsp_state <= S_IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (~bypass & target_resp & fifo_full) overflow_q <= 1'b1;

            if (accept_rd && !host_resp && outstanding_q != OUT_MAX_C)
                outstanding_q <= outstanding_q + 1'b1;
            else if (host_resp && !accept_rd && outstanding_q != '0)
                outstanding_q <= outstanding_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_split_bus_delayer_pro.sv
// Randomised bench for split_bus_delayer_pro: scoreboard of read data in
// issue order, outstanding-count model, and directed latency/limit scenarios.
module tb_split_bus_delayer_pro;
    localparam int MAXO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  mode_i;
    logic [3:0]  fixed_req_delay_i;
    logic [2:0]  fixed_resp_delay_i;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic [3:0]  host_be;
    logic        host_ack, host_resp;
    logic [31:0] host_rdata;
    logic        target_req, target_we;
    logic [31:0] target_addr, target_wdata;
    logic [3:0]  target_be;
    logic        target_ack, target_resp;
    logic [31:0] target_rdata;
    logic [3:0]  outstanding_o;
    logic        overflow_o;

    split_bus_delayer_pro dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
        .fixed_req_delay_i(fixed_req_delay_i), .fixed_resp_delay_i(fixed_resp_delay_i),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_be(host_be), .host_ack(host_ack),
        .host_resp(host_resp), .host_rdata(host_rdata),
        .target_req(target_req), .target_we(target_we), .target_addr(target_addr),
        .target_wdata(target_wdata), .target_be(target_be), .target_ack(target_ack),
        .target_resp(target_resp), .target_rdata(target_rdata),
        .outstanding_o(outstanding_o), .overflow_o(overflow_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tgt_data[$];
    int          tgt_due[$];
    int tgt_ack_mode = 0;   // 0 always ack, 1 random
    int tgt_resp_mode = 0;  // 0 fixed latency, 1 random, 2 hold, 3 unsolicited spray
    int tgt_lat = 2;
    int spray_left = 0;
    bit sb_off = 0;
    int out_model = 0;
    int last_tresp_cyc = 0, last_hresp_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Memory target: in-order responses, data derived from the address seen.
    initial begin
        target_ack = 0; target_resp = 0; target_rdata = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            target_ack   = (tgt_ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            target_resp  = 0;
            target_rdata = 0;
            if (tgt_resp_mode == 3) begin
                if (spray_left > 0) begin
                    target_resp = 1; target_rdata = $urandom; spray_left--;
                end
            end else if (tgt_data.size() > 0 && tgt_due[0] <= cyc && tgt_resp_mode != 2 &&
                         (tgt_resp_mode != 1 || $urandom_range(0, 2) != 0)) begin
                target_resp  = 1;
                target_rdata = tgt_data.pop_front();
                void'(tgt_due.pop_front());
            end
            if (target_resp) last_tresp_cyc = cyc;
            #4;
            if (rst_i) begin
                tgt_data.delete(); tgt_due.delete();
            end else if (target_req && target_ack) begin
                check("addr_pass", target_addr, host_addr);
                check("wdata_pass", {target_we, target_be, target_wdata}, {host_we, host_be, host_wdata});
                if (!target_we) begin
                    tgt_data.push_back(data_of(target_addr));
                    tgt_due.push_back(cyc + ((tgt_resp_mode == 0) ? tgt_lat : 1));
                end
            end
        end
    end

    // Monitor: scoreboard pop on host_resp, outstanding model, room rule.
    initial forever begin
        @(negedge clk_i);
        #4;
        if (rst_i) begin
            exp_q.delete();
            out_model = 0;
        end else begin
            bit inc, dec;
            check("outstanding", outstanding_o, out_model);
            inc = target_req && target_ack && !target_we;
            dec = host_resp;
            if (host_resp) begin
                last_hresp_cyc = cyc;
                if (!sb_off) begin
                    if (exp_q.size() == 0) check("unexpected_resp", host_resp, 0);
                    else check("rdata", host_rdata, exp_q.pop_front());
                end
            end
            if (inc) check("room", out_model < MAXO, 1);
            if (inc && !dec && out_model < MAXO) out_model++;
            else if (dec && !inc && out_model > 0) out_model--;
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr, input int block, output int lat);
        int start, first, n, seen;
        bit done;
        @(negedge clk_i);
        host_req = 1; host_we = we; host_addr = addr;
        host_wdata = $urandom; host_be = 4'($urandom);
        #4;
        start = cyc; first = -1; n = 0; seen = 0; done = 0;
        while (!done && n < 300) begin
            if (block > 0 && n < block && target_req) seen++;
            if (block > 0 && n == block) begin
                check("limit_block", seen, 0);
                tgt_resp_mode = 1;
            end
            if (target_req && first < 0) first = cyc;
            if (host_ack) done = 1;
            else begin
                @(negedge clk_i); #4; n++;
            end
        end
        if (block > 0 && n < block) check("limit_block", seen, 0);
        if (block > 0) tgt_resp_mode = 1;
        check("req_accept", done, 1);
        if (done) begin
            if (!we) exp_q.push_back(data_of(addr));
            @(posedge clk_i); #1;
            lat = first - start;
        end else lat = -1;
        host_req = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(negedge clk_i); #4; n++;
        end while (!(exp_q.size() == 0 && outstanding_o == 0) && n < 600);
        check("drain", (exp_q.size() == 0 && outstanding_o == 0), 1);
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode_i = m;
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        int lat, d, r;
        rst_i = 1; mode_i = 0; fixed_req_delay_i = 0; fixed_resp_delay_i = 0;
        host_req = 1; host_we = 0; host_addr = 0; host_wdata = 0; host_be = 0;
        repeat (3) @(negedge clk_i);
        #4;
        check("rst_target_req", target_req, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_host_resp", host_resp, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_overflow", overflow_o, 0);
        host_req = 0;
        @(negedge clk_i); rst_i = 0;

        // Bypass
        tgt_lat = 2;
        do_req(0, 32'h100, 0, lat);
        check("byp_req_lat", lat, 0);
        wait_drain();
        check("byp_resp_lat", last_hresp_cyc - last_tresp_cyc, 0);
        do_req(1, 32'h104, 0, lat);
        check("byp_wr_lat", lat, 0);

        // Fixed mode, nominal and saturated delays
        tgt_lat = 1;
        fixed_req_delay_i = 3; fixed_resp_delay_i = 2;
        set_mode(1);
        do_req(0, 32'h200, 0, lat);
        check("fix_req_lat", lat, 5);
        wait_drain();
        check("fix_resp_lat", last_hresp_cyc - last_tresp_cyc, 4);
        fixed_req_delay_i = 15; fixed_resp_delay_i = 7;
        do_req(0, 32'h204, 0, lat);
        check("fix_req_sat", lat, 10);
        wait_drain();
        check("fix_resp_sat", last_hresp_cyc - last_tresp_cyc, 8);

        // Fixed mode, random delays and random target
        tgt_ack_mode = 1; tgt_resp_mode = 1;
        for (int i = 0; i < 20; i++) begin
            d = $urandom_range(0, 15); r = $urandom_range(0, 7);
            fixed_req_delay_i = 4'(d); fixed_resp_delay_i = 3'(r);
            do_req(1'($urandom_range(0, 1)), $urandom, 0, lat);
            check("fix_rnd_lat", lat, ((d > 8) ? 8 : d) + 2);
        end
        wait_drain();

        // Outstanding limit: writes pass, the ninth read waits for a response
        tgt_ack_mode = 0; tgt_resp_mode = 2;
        fixed_req_delay_i = 0; fixed_resp_delay_i = 0;
        for (int i = 0; i < MAXO; i++) do_req(0, 32'h300 + 32'(i * 4), 0, lat);
        check("limit_full", outstanding_o, MAXO);
        do_req(1, 32'h400, 0, lat);
        check("limit_wr_lat", lat, 2);
        do_req(0, 32'h404, 15, lat);
        wait_drain();

        // Mode change deferred while reads are pending
        tgt_resp_mode = 2; fixed_req_delay_i = 2;
        do_req(0, 32'h500, 0, lat);
        do_req(0, 32'h504, 0, lat);
        mode_i = 0;
        repeat (5) @(negedge clk_i);
        do_req(1, 32'h508, 0, lat);
        check("mode_defer_lat", lat, 4);
        tgt_resp_mode = 0;
        wait_drain();
        repeat (3) @(negedge clk_i);
        do_req(1, 32'h50C, 0, lat);
        check("mode_applied_lat", lat, 0);

        // Random mode ordering
        tgt_ack_mode = 1; tgt_resp_mode = 1;
        set_mode(2);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_req(1, $urandom, 0, lat);
                check("rnd_wr_lat_range", (lat >= 2 && lat <= 10), 1);
            end
            do_req(0, 32'h1000 + 32'(i * 4), 0, lat);
            check("rnd_lat_range", (lat >= 2 && lat <= 10), 1);
        end
        wait_drain();
        check("rnd_no_overflow", overflow_o, 0);

        // Reset in the middle of a request delay
        tgt_ack_mode = 0; tgt_resp_mode = 2; fixed_req_delay_i = 8;
        set_mode(1);
        fixed_req_delay_i = 0;
        do_req(0, 32'h600, 0, lat);
        do_req(0, 32'h604, 0, lat);
        fixed_req_delay_i = 8;
        @(negedge clk_i);
        host_req = 1; host_we = 0; host_addr = 32'h608;
        repeat (3) @(negedge clk_i);
        #4;
        check("wait_no_req", target_req, 0);
        check("pre_rst_out", outstanding_o, 2);
        @(negedge clk_i); rst_i = 1;
        #4;
        check("midrst_target_req", target_req, 0);
        check("midrst_outstanding", outstanding_o, 0);
        host_req = 0; mode_i = 0; tgt_resp_mode = 0; tgt_lat = 1;
        @(negedge clk_i); rst_i = 0;
        do_req(0, 32'h700, 0, lat);
        check("post_rst_bypass", lat, 0);
        wait_drain();

        // Overflow from unsolicited responses with a stalled output stage
        fixed_resp_delay_i = 6;
        set_mode(1);
        check("pre_overflow", overflow_o, 0);
        sb_off = 1; spray_left = 24; tgt_resp_mode = 3;
        repeat (30) @(negedge clk_i);
        #4;
        check("overflow_set", overflow_o, 1);
        repeat (40) @(negedge clk_i);
        #4;
        check("overflow_sticky", overflow_o, 1);
        @(negedge clk_i); rst_i = 1;
        #4;
        check("overflow_rst", overflow_o, 0);
        @(negedge clk_i); rst_i = 0; sb_off = 0; tgt_resp_mode = 0;
        repeat (2) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
